// File: rtl/collision_lookup_arbiter_if.sv
// collision_lookup_arbiter_if: probe request/response bus plus collision ROM port
interface collision_lookup_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*12-1:0] req_x;
    logic [N_REQ*12-1:0] req_y;
    logic [N_REQ-1:0]    gnt;
    logic [11:0]         rom_addr;
    logic [1:0]          rom_data;
    logic [N_REQ-1:0]    rsp_valid;
    logic [1:0]          rsp_tile;
    logic                rsp_oob;
    logic                busy;
    modport master (
        output req, req_x, req_y, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_tile, rsp_oob, busy
    );
    modport slave (
        input  req, req_x, req_y, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_tile, rsp_oob, busy
    );
endinterface

// File: rtl/collision_lookup_arbiter.sv
// collision_lookup_arbiter: round-robin sharing of the collision map ROM, fixed 3-cycle lookup latency
module collision_lookup_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         TILE_SIZE = 12,
    parameter int         MAP_W     = 64,
    parameter int         MAP_H     = 48,
    parameter logic [1:0] OOB_TILE  = 2'b01
) (
    input logic clk,
    input logic rst,
    collision_lookup_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] lsb = 1;
    logic [IW-1:0] ptr, win, id1, id2;
    logic          found, accept, v1, v2, oob0, oob1, oob2;
    logic [11:0]   x0, y0, tx0, ty0, addr0;
    // Scan from the highest offset down so the nearest requester after ptr wins.
    always_comb begin
        win = ptr;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req[(int'(ptr) + k) % N_REQ]) begin
                win = IW'((int'(ptr) + k) % N_REQ);
                found = 1'b1;
            end
    end
    assign accept  = found && !rst;
    assign bus.gnt = accept ? lsb << win : '0;
    assign x0      = bus.req_x[12*win +: 12];
    assign y0      = bus.req_y[12*win +: 12];
    assign tx0     = x0 / 12'(TILE_SIZE);
    assign ty0     = y0 / 12'(TILE_SIZE);
    assign oob0    = (tx0 >= 12'(MAP_W)) || (ty0 >= 12'(MAP_H));
    assign addr0   = ty0 * 12'(MAP_W) + tx0;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            id1           <= '0;
            id2           <= '0;
            oob1          <= 1'b0;
            oob2          <= 1'b0;
            bus.rom_addr  <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_tile  <= 2'b00;
            bus.rsp_oob   <= 1'b0;
        end else begin
            if (accept) begin
                ptr          <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
                bus.rom_addr <= addr0;
                id1          <= win;
                oob1         <= oob0;
            end
            v1            <= accept;
            v2            <= v1;
            id2           <= id1;
            oob2          <= oob1;
            bus.rsp_valid <= v2 ? lsb << id2 : '0;
            if (v2) begin
                bus.rsp_tile <= oob2 ? OOB_TILE : bus.rom_data;
                bus.rsp_oob  <= oob2;
            end
        end
    end
    assign bus.busy = v1 | v2 | (|bus.rsp_valid);
endmodule

// File: tb/tb_collision_lookup_arbiter.sv
// tb_collision_lookup_arbiter: directed and random checks against a queue-based lookup model
module tb_collision_lookup_arbiter;
    localparam int N = 4;
    typedef struct {
        int         id;
        logic [1:0] tile;
        logic       oob;
        int         due;
    } item_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    collision_lookup_arbiter_if #(.N_REQ(N)) bus ();
    collision_lookup_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic logic [1:0] rom_fn(input int a);
        return 2'((a * 37 + (a >> 5)) % 4);
    endfunction
    always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));
    int          n_chk = 0, n_fail = 0, cyc = 0, mptr = 0;
    logic [11:0] m_addr = '0;
    logic [1:0]  ltile = '0;
    logic        loob = 1'b0;
    logic [N-1:0] last_gnt = '0, last_rsp = '0;
    logic        last_busy = 1'b0;
    item_t       q[$];
    logic [N-1:0] gseq[8];
    int          cnt;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    task automatic set_xy(input int i, input int x, input int y);
        bus.req_x[12*i +: 12] = 12'(x);
        bus.req_y[12*i +: 12] = 12'(y);
    endtask
    // One clock of the model: check this cycle's outputs, record any accept, advance.
    task automatic step();
        logic [N-1:0] eg, ev;
        int g, x, y, tx, ty, a;
        logic o;
        #1;
        eg = '0;
        ev = '0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j = (mptr + k) % N;
            if (g < 0 && bus.req[j]) g = j;
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", bus.gnt, eg);
        last_gnt = bus.gnt;
        chk("busy", bus.busy, q.size() != 0);
        last_busy = bus.busy;
        if (q.size() != 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1'b1;
            ltile = q[0].tile;
            loob = q[0].oob;
            void'(q.pop_front());
        end
        chk("rsp_valid", bus.rsp_valid, ev);
        last_rsp = bus.rsp_valid;
        chk("rsp_tile", bus.rsp_tile, ltile);
        chk("rsp_oob", bus.rsp_oob, loob);
        chk("rom_addr", bus.rom_addr, m_addr);
        a = 0;
        if (g >= 0) begin
            x = int'(bus.req_x[12*g +: 12]);
            y = int'(bus.req_y[12*g +: 12]);
            tx = x / 12;
            ty = y / 12;
            o = (tx >= 64) || (ty >= 48);
            a = (ty * 64 + tx) % 4096;
            q.push_back('{g, o ? 2'b01 : rom_fn(a), o, cyc + 3});
            mptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (g >= 0) m_addr = 12'(a);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("gnt_in_rst", bus.gnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mptr = 0;
        m_addr = '0;
        ltile = '0;
        loob = 1'b0;
        cyc++;
    endtask
    initial begin
        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_tile", bus.rsp_tile, 0);
        step();
        // single lookup from requester 0
        bus.req = 4'b0001;
        set_xy(0, 39, 521);
        step();
        chk("t1_gnt", last_gnt, 4'b0001);
        bus.req = '0;
        chk("t1_addr", bus.rom_addr, 2755);
        step();
        step();
        step();
        chk("t1_valid", last_rsp, 4'b0001);
        chk("t1_tile", bus.rsp_tile, rom_fn(2755));
        chk("t1_oob", bus.rsp_oob, 0);
        // all requesters continuously from ptr 0
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_xy(i, $urandom_range(0, 767), $urandom_range(0, 575));
        for (int t = 0; t < 8; t++) begin
            step();
            gseq[t] = last_gnt;
            for (int i = 0; i < N; i++)
                if (last_gnt[i]) set_xy(i, $urandom_range(0, 767), $urandom_range(0, 575));
        end
        for (int t = 0; t < 8; t++) chk("t2_order", gseq[t], 4'b0001 << (t % 4));
        bus.req = '0;
        repeat (4) step();
        // out-of-range x, then the in-range corner
        bus.req = 4'b0100;
        set_xy(2, 768, 10);
        step();
        bus.req = '0;
        step();
        step();
        step();
        chk("t3_valid", last_rsp, 4'b0100);
        chk("t3_tile", bus.rsp_tile, 2'b01);
        chk("t3_oob", bus.rsp_oob, 1);
        bus.req = 4'b0001;
        set_xy(0, 767, 575);
        step();
        bus.req = '0;
        chk("t3_corner_addr", bus.rom_addr, 3071);
        step();
        step();
        step();
        chk("t3_corner_oob", bus.rsp_oob, 0);
        chk("t3_corner_tile", bus.rsp_tile, rom_fn(3071));
        // ptr moved to 2, then req=1011
        bus.req = 4'b0010;
        step();
        bus.req = 4'b1011;
        set_xy(3, 100, 200);
        step();
        gseq[0] = last_gnt;
        step();
        gseq[1] = last_gnt;
        step();
        gseq[2] = last_gnt;
        chk("t4_g0", gseq[0], 4'b1000);
        chk("t4_g1", gseq[1], 4'b0001);
        chk("t4_g2", gseq[2], 4'b0010);
        bus.req = '0;
        repeat (4) step();
        // back-to-back lookups from requester 1
        cnt = 0;
        bus.req = 4'b0010;
        for (int t = 0; t < 5; t++) begin
            set_xy(1, 13 * t + 5, 40 * t + 7);
            step();
            if (last_rsp[1]) cnt++;
        end
        bus.req = '0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("t5_busy", last_busy, 1);
            if (last_rsp[1]) cnt++;
        end
        step();
        chk("t5_pulses", cnt, 5);
        // reset one cycle after two grants
        bus.req = 4'b1001;
        step();
        step();
        do_reset();
        bus.req = 4'b0110;
        step();
        chk("t6_gnt", last_gnt, 4'b0010);
        chk("t6_busy", last_busy, 0);
        bus.req = '0;
        repeat (4) step();
        // random traffic with the hold-until-granted rule
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++)
                if (!(bus.req[i] && !last_gnt[i])) begin
                    bus.req[i] = ($urandom % 3) != 0;
                    set_xy(i, $urandom_range(0, 800), $urandom_range(0, 620));
                end
            step();
        end
        bus.req = '0;
        repeat (4) step();
        chk("drain_busy", bus.busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
